// File: rtl/jtsdram_pkg.sv
// jtsdram_pkg: constants and state encoding shared by the bank checkers
// and the test sequencer.
package jtsdram_pkg;

  localparam int KEY_W    = 5;
  localparam int DW       = 16;
  localparam int TOUT_DEF = 255;

  // Value recorded as the failing data when a word never arrives
  localparam logic [DW-1:0] TOUT_DATA = 16'hDEAD;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4
  } st_t;

endpackage

// File: rtl/jtsdram_chk_log.sv
// jtsdram_chk_log: holds the address and data of the first error seen
// since reset; later errors leave the record untouched.
module jtsdram_chk_log #(
  parameter int AW = 22,
  parameter int DW = 16
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          err,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_data
);

  logic seen;

  // Capture once, on the first error after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (err && !seen) begin
      seen      <= 1'b1;
      fail_addr <= addr;
      fail_data <= data;
    end
  end

endmodule

// File: rtl/jtsdram_bank_chk.sv
// jtsdram_bank_chk: per-bank read checker. On rd_start it reads 2**LW
// words from the region selected by key and compares each against
// data_ref+index, keeping a sticky bad flag and a saturating error count.
// Define JTSDRAM_CHK_LOG_EN to build first-error logging (fail_addr and
// fail_data); otherwise those outputs are tied to zero.
module jtsdram_bank_chk
  import jtsdram_pkg::*;
#(
  parameter int AW   = 22,
  parameter int BA   = 0,
  parameter int LW   = 4,
  parameter int TOUT = TOUT_DEF
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_start,
  input  logic [KEY_W-1:0] key,
  input  logic [DW-1:0]    data_ref,
  output logic             ba_rd,
  output logic [AW-1:0]    ba_addr,
  input  logic             ba_ack,
  input  logic             ba_rdy,
  input  logic [DW-1:0]    ba_dout,
  output logic             done,
  output logic             bad,
  output logic [15:0]      err_cnt,
  output logic [AW-1:0]    fail_addr,
  output logic [DW-1:0]    fail_data,
  output logic [1:0]       dbg_ba
);

  localparam int TW = (TOUT < 1) ? 1 : $clog2(TOUT + 1);
  localparam logic [LW-1:0] IDX_LAST = '1;

  st_t              st;
  logic [KEY_W-1:0] key_l;
  logic [DW-1:0]    ref_l;
  logic [DW-1:0]    rdata;
  logic [LW-1:0]    idx;
  logic [TW-1:0]    timer;
  logic             tout_flag;
  logic             err_chk;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Address is built from the latched key and word index so it stays
  // stable for the whole request.
  assign ba_addr = (AW'(key_l) << (AW - KEY_W)) | AW'(idx);
  assign dbg_ba  = 2'(BA);

  // A timed-out word counts as an error without looking at the data
  assign err_chk = (st == ST_CHK) &&
                   (tout_flag || (rdata != (ref_l + DW'(idx))));

  // Pass sequencing: request, wait for data, check, advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      ba_rd     <= 1'b0;
      done      <= 1'b0;
      bad       <= 1'b0;
      err_cnt   <= 16'd0;
      key_l     <= '0;
      ref_l     <= '0;
      rdata     <= '0;
      idx       <= '0;
      timer     <= '0;
      tout_flag <= 1'b0;
    end else begin
      case (st)
        ST_IDLE, ST_DONE: begin
          if (rd_start) begin
            key_l <= key;
            ref_l <= data_ref;
            idx   <= '0;
            done  <= 1'b0;
            ba_rd <= 1'b1;
            st    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ba_ack) begin
            ba_rd     <= 1'b0;
            timer     <= '0;
            tout_flag <= 1'b0;
            if (ba_rdy) begin
              rdata <= ba_dout;
              st    <= ST_CHK;
            end else begin
              st    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (ba_rdy) begin
            rdata <= ba_dout;
            st    <= ST_CHK;
          end else if (timer == TW'(TOUT)) begin
            tout_flag <= 1'b1;
            st        <= ST_CHK;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_CHK: begin
          if (err_chk) begin
            bad     <= 1'b1;
            err_cnt <= sat_inc(err_cnt);
          end
          if (idx == IDX_LAST) begin
            done <= 1'b1;
            st   <= ST_DONE;
          end else begin
            idx   <= idx + 1'b1;
            ba_rd <= 1'b1;
            st    <= ST_REQ;
          end
        end
        default: begin
          ba_rd <= 1'b0;
          st    <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef JTSDRAM_CHK_LOG_EN
  logic [DW-1:0] log_data;

  assign log_data = tout_flag ? TOUT_DATA : rdata;

  jtsdram_chk_log #(
    .AW (AW),
    .DW (DW)
  ) u_log (
    .clk       (clk),
    .rst_n     (rst_n),
    .err       (err_chk),
    .addr      (ba_addr),
    .data      (log_data),
    .fail_addr (fail_addr),
    .fail_data (fail_data)
  );
`else
  assign fail_addr = '0;
  assign fail_data = '0;
`endif

endmodule

// File: tb/tb_jtsdram_bank_chk.sv
// tb_jtsdram_bank_chk: bench for the bank read checker with a randomised
// SDRAM bank model and a pass-level reference model.
module tb_jtsdram_bank_chk;

  localparam int AW = 22;
  localparam int LW = 4;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_start;
  logic [4:0]    key;
  logic [15:0]   data_ref;
  logic          ba_rd;
  logic [AW-1:0] ba_addr;
  logic          ba_ack;
  logic          ba_rdy;
  logic [15:0]   ba_dout;
  logic          done;
  logic          bad;
  logic [15:0]   err_cnt;
  logic [AW-1:0] fail_addr;
  logic [15:0]   fail_data;
  logic [1:0]    dbg_ba;

  int checks = 0;
  int errors = 0;

  // Bank model controls
  int          ack_dly  = 0;
  int          rd_lat   = 3;
  bit          same_cyc = 1'b0;
  logic [15:0] corrupt_mask = '0;
  logic [15:0] drop_mask    = '0;
  logic [15:0] mem_ref      = '0;
  logic [AW-1:0] addr_q[$];

  // Reference model state
  logic [15:0]   m_cnt;
  bit            m_bad;
  bit            m_logged;
  logic [AW-1:0] m_faddr;
  logic [15:0]   m_fdata;

  jtsdram_bank_chk #(.AW(AW), .BA(2), .LW(LW), .TOUT(255)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_start  (rd_start),
    .key       (key),
    .data_ref  (data_ref),
    .ba_rd     (ba_rd),
    .ba_addr   (ba_addr),
    .ba_ack    (ba_ack),
    .ba_rdy    (ba_rdy),
    .ba_dout   (ba_dout),
    .done      (done),
    .bad       (bad),
    .err_cnt   (err_cnt),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .dbg_ba    (dbg_ba)
  );

  always #5 clk = ~clk;

  // SDRAM bank model: acknowledges each request after ack_dly cycles and
  // returns data rd_lat cycles after the ack (or together with it).
  logic [AW-1:0] cur;
  int            wi;
  logic [15:0]   wd;
  initial begin
    ba_ack = 1'b0; ba_rdy = 1'b0; ba_dout = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && ba_rd) begin
        cur = ba_addr;
        addr_q.push_back(cur);
        wi = int'(cur[LW-1:0]);
        wd = mem_ref + 16'(wi);
        if (corrupt_mask[wi]) wd = 16'h0000;
        repeat (ack_dly) begin @(posedge clk); #1; end
        ba_ack = 1'b1;
        if (same_cyc) begin ba_rdy = 1'b1; ba_dout = wd; end
        @(posedge clk); #1;
        ba_ack = 1'b0; ba_rdy = 1'b0;
        if (!same_cyc && !drop_mask[wi]) begin
          repeat (rd_lat - 1) begin @(posedge clk); #1; end
          ba_rdy = 1'b1; ba_dout = wd;
          @(posedge clk); #1;
          ba_rdy = 1'b0;
        end
      end
    end
  end

  function automatic logic [AW-1:0] exp_addr(input logic [4:0] k, input int i);
    return (AW'(k) << (AW - 5)) | AW'(i);
  endfunction

  task automatic model_clear();
    m_cnt = '0; m_bad = 1'b0; m_logged = 1'b0; m_faddr = '0; m_fdata = '0;
  endtask

  // Whole-pass outcome: every word in order, errors for corrupt or lost data
  task automatic model_pass(input logic [4:0] k, input logic [15:0] r);
    logic [15:0] got;
    bit          e;
    for (int i = 0; i < NW; i++) begin
      got = corrupt_mask[i] ? 16'h0000 : r + 16'(i);
      e   = drop_mask[i] || (got != r + 16'(i));
      if (e) begin
        m_bad = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (!m_logged) begin
          m_logged = 1'b1;
          m_faddr  = exp_addr(k, i);
          m_fdata  = drop_mask[i] ? 16'hDEAD : got;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_clear();
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    addr_q.delete();
  endtask

  task automatic run_pass(input logic [4:0] k, input logic [15:0] r, output int cyc);
    key = k; data_ref = r; mem_ref = r;
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 6000) begin @(posedge clk); #1; cyc++; end
    if (done !== 1'b1) cyc = -1;
  endtask

  function automatic logic [AW-1:0] exp_faddr();
`ifdef JTSDRAM_CHK_LOG_EN
    return m_faddr;
`else
    return '0;
`endif
  endfunction

  function automatic logic [15:0] exp_fdata();
`ifdef JTSDRAM_CHK_LOG_EN
    return m_fdata;
`else
    return '0;
`endif
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; rd_start = 1'b0; key = '0; data_ref = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ba_rd !== 1'b0) begin errors++; $display("FAIL reset_ba_rd got=%0b exp=0", ba_rd); end
    checks++; if (ba_addr !== '0) begin errors++; $display("FAIL reset_ba_addr got=%0h exp=0", ba_addr); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL reset_bad got=%0b exp=0", bad); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt got=%0h exp=0", err_cnt); end
    checks++; if (fail_addr !== '0 || fail_data !== '0) begin errors++; $display("FAIL reset_fail got=%0h/%0h exp=0/0", fail_addr, fail_data); end
    checks++; if (dbg_ba !== 2'd2) begin errors++; $display("FAIL reset_dbg_ba got=%0d exp=2", dbg_ba); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    addr_q.delete();
  endtask

  task automatic test_clean();
    int cyc;
    ack_dly = 0; rd_lat = 3; same_cyc = 1'b0; corrupt_mask = '0; drop_mask = '0;
    addr_q.delete();
    run_pass(5'h0A, 16'h1234, cyc);
    model_pass(5'h0A, 16'h1234);
    checks++; if (cyc < 0) begin errors++; $display("FAIL clean_done_timeout got=no_done exp=done"); end
    checks++; if (addr_q.size() != NW) begin errors++; $display("FAIL clean_nreads got=%0d exp=%0d", addr_q.size(), NW); end
    for (int i = 0; i < NW && i < addr_q.size(); i++) begin
      checks++; if (addr_q[i] !== exp_addr(5'h0A, i)) begin errors++; $display("FAIL clean_addr%0d got=%0h exp=%0h", i, addr_q[i], exp_addr(5'h0A, i)); end
    end
    checks++; if (bad !== m_bad) begin errors++; $display("FAIL clean_bad got=%0b exp=%0b", bad, m_bad); end
    checks++; if (err_cnt !== m_cnt) begin errors++; $display("FAIL clean_err_cnt got=%0h exp=%0h", err_cnt, m_cnt); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL clean_done_held got=%0b exp=1", done); end
    checks++; if (ba_rd !== 1'b0) begin errors++; $display("FAIL clean_idle_rd got=%0b exp=0", ba_rd); end
  endtask

  task automatic test_single_err();
    int cyc;
    do_reset();
    ack_dly = 0; rd_lat = 3; same_cyc = 1'b0; corrupt_mask = 16'h0080; drop_mask = '0;
    run_pass(5'h0A, 16'h1234, cyc);
    model_pass(5'h0A, 16'h1234);
    checks++; if (cyc < 0) begin errors++; $display("FAIL single_done_timeout got=no_done exp=done"); end
    checks++; if (addr_q.size() != NW) begin errors++; $display("FAIL single_nreads got=%0d exp=%0d", addr_q.size(), NW); end
    checks++; if (bad !== 1'b1) begin errors++; $display("FAIL single_bad got=%0b exp=1", bad); end
    checks++; if (err_cnt !== m_cnt) begin errors++; $display("FAIL single_err_cnt got=%0h exp=%0h", err_cnt, m_cnt); end
    checks++; if (fail_addr !== exp_faddr()) begin errors++; $display("FAIL single_fail_addr got=%0h exp=%0h", fail_addr, exp_faddr()); end
    checks++; if (fail_data !== exp_fdata()) begin errors++; $display("FAIL single_fail_data got=%0h exp=%0h", fail_data, exp_fdata()); end
  endtask

  task automatic test_timeout();
    int cyc;
    do_reset();
    ack_dly = 0; rd_lat = 3; same_cyc = 1'b0; corrupt_mask = '0; drop_mask = 16'h0004;
    run_pass(5'h13, 16'hBEEF, cyc);
    model_pass(5'h13, 16'hBEEF);
    drop_mask = '0;
    checks++; if (cyc < 0) begin errors++; $display("FAIL tout_done_timeout got=no_done exp=done"); end
    checks++; if (cyc < 256) begin errors++; $display("FAIL tout_duration got=%0d exp>=256", cyc); end
    checks++; if (addr_q.size() != NW) begin errors++; $display("FAIL tout_nreads got=%0d exp=%0d", addr_q.size(), NW); end
    checks++; if (err_cnt !== m_cnt) begin errors++; $display("FAIL tout_err_cnt got=%0h exp=%0h", err_cnt, m_cnt); end
    checks++; if (bad !== 1'b1) begin errors++; $display("FAIL tout_bad got=%0b exp=1", bad); end
    checks++; if (fail_addr !== exp_faddr()) begin errors++; $display("FAIL tout_fail_addr got=%0h exp=%0h", fail_addr, exp_faddr()); end
    checks++; if (fail_data !== exp_fdata()) begin errors++; $display("FAIL tout_fail_data got=%0h exp=%0h", fail_data, exp_fdata()); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    ack_dly = 0; same_cyc = 1'b1; corrupt_mask = '0; drop_mask = '0;
    addr_q.delete();
    run_pass(5'h05, 16'h0F00, cyc);
    model_pass(5'h05, 16'h0F00);
    same_cyc = 1'b0;
    checks++; if (cyc != 2 * NW) begin errors++; $display("FAIL b2b_cycles got=%0d exp=%0d", cyc, 2 * NW); end
    checks++; if (addr_q.size() != NW) begin errors++; $display("FAIL b2b_nreads got=%0d exp=%0d", addr_q.size(), NW); end
    checks++; if (err_cnt !== m_cnt) begin errors++; $display("FAIL b2b_err_cnt got=%0h exp=%0h", err_cnt, m_cnt); end
  endtask

  task automatic test_random();
    int          cyc;
    logic [4:0]  k;
    logic [15:0] r;
    for (int n = 0; n < 4; n++) begin
      k = 5'($urandom); r = 16'($urandom);
      ack_dly = int'($urandom_range(0, 2)); rd_lat = int'($urandom_range(1, 4));
      same_cyc = 1'($urandom_range(0, 1));
      corrupt_mask = 16'($urandom & $urandom & $urandom); drop_mask = '0;
      addr_q.delete();
      run_pass(k, r, cyc);
      model_pass(k, r);
      checks++; if (cyc < 0) begin errors++; $display("FAIL rnd%0d_done_timeout got=no_done exp=done", n); end
      checks++; if (addr_q.size() != NW) begin errors++; $display("FAIL rnd%0d_nreads got=%0d exp=%0d", n, addr_q.size(), NW); end
      for (int i = 0; i < NW && i < addr_q.size(); i++) begin
        checks++; if (addr_q[i] !== exp_addr(k, i)) begin errors++; $display("FAIL rnd%0d_addr%0d got=%0h exp=%0h", n, i, addr_q[i], exp_addr(k, i)); end
      end
      checks++; if (err_cnt !== m_cnt) begin errors++; $display("FAIL rnd%0d_err_cnt got=%0h exp=%0h", n, err_cnt, m_cnt); end
      checks++; if (bad !== m_bad) begin errors++; $display("FAIL rnd%0d_bad got=%0b exp=%0b", n, bad, m_bad); end
      checks++; if (fail_addr !== exp_faddr() || fail_data !== exp_fdata()) begin errors++; $display("FAIL rnd%0d_fail got=%0h/%0h exp=%0h/%0h", n, fail_addr, fail_data, exp_faddr(), exp_fdata()); end
    end
    corrupt_mask = '0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    ack_dly = 0; rd_lat = 3; same_cyc = 1'b0; corrupt_mask = 16'h0001; drop_mask = '0;
    addr_q.delete();
    key = 5'h1C; data_ref = 16'h5555; mem_ref = 16'h5555;
    rd_start = 1'b1; @(posedge clk); #1; rd_start = 1'b0;
    cyc = 0;
    while (addr_q.size() < 6 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    checks++; if (addr_q.size() < 6) begin errors++; $display("FAIL rstmid_reach_idx5 got=%0d exp=6", addr_q.size()); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ba_rd !== 1'b0) begin errors++; $display("FAIL rstmid_ba_rd got=%0b exp=0", ba_rd); end
    checks++; if (bad !== 1'b0 || err_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_err got=%0b/%0h exp=0/0", bad, err_cnt); end
    checks++; if (ba_addr !== '0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_addr_done got=%0h/%0b exp=0/0", ba_addr, done); end
    checks++; if (fail_addr !== '0 || fail_data !== '0) begin errors++; $display("FAIL rstmid_fail got=%0h/%0h exp=0/0", fail_addr, fail_data); end
    @(posedge clk); #1;
    corrupt_mask = '0;
    do_reset();
    run_pass(5'h1C, 16'h5555, cyc);
    model_pass(5'h1C, 16'h5555);
    checks++; if (addr_q.size() != NW) begin errors++; $display("FAIL rstmid_nreads got=%0d exp=%0d", addr_q.size(), NW); end
    checks++; if (addr_q.size() > 0 && addr_q[0] !== exp_addr(5'h1C, 0)) begin errors++; $display("FAIL rstmid_restart got=%0h exp=%0h", addr_q[0], exp_addr(5'h1C, 0)); end
    checks++; if (err_cnt !== m_cnt || done !== 1'b1) begin errors++; $display("FAIL rstmid_after got=%0h/%0b exp=%0h/1", err_cnt, done, m_cnt); end
  endtask

  task automatic test_saturation();
    int cyc;
    ack_dly = 1; rd_lat = 2; same_cyc = 1'b0; corrupt_mask = 16'h0124; drop_mask = '0;
    force dut.err_cnt = 16'hFFFE;
    @(posedge clk); #1;
    release dut.err_cnt;
    m_cnt = 16'hFFFE;
    addr_q.delete();
    key = 5'h11; data_ref = 16'h7000; mem_ref = 16'h7000;
    rd_start = 1'b1; @(posedge clk); #1; rd_start = 1'b0;
    // second start with different inputs while the pass is in flight
    key = 5'h0E; data_ref = 16'h0001; rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL sat_done_low got=%0b exp=0", done); end
    cyc = 0;
    while (done !== 1'b1 && cyc < 6000) begin @(posedge clk); #1; cyc++; end
    model_pass(5'h11, 16'h7000);
    corrupt_mask = '0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL sat_done_timeout got=no_done exp=done"); end
    checks++; if (addr_q.size() != NW) begin errors++; $display("FAIL sat_nreads got=%0d exp=%0d", addr_q.size(), NW); end
    for (int i = 0; i < NW && i < addr_q.size(); i++) begin
      checks++; if (addr_q[i] !== exp_addr(5'h11, i)) begin errors++; $display("FAIL sat_addr%0d got=%0h exp=%0h", i, addr_q[i], exp_addr(5'h11, i)); end
    end
    checks++; if (err_cnt !== 16'hFFFF || err_cnt !== m_cnt) begin errors++; $display("FAIL sat_err_cnt got=%0h exp=%0h", err_cnt, m_cnt); end
    checks++; if (bad !== 1'b1) begin errors++; $display("FAIL sat_bad got=%0b exp=1", bad); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_err();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
